retire_trace_buffer: RTL and testbench
======================================

// Module: retire_trace_buffer
// PURPOSE
//  Synthesizable trace capture for the datapath. Records one entry per retired instruction
//  (PC, destination register, write flag, write data, timestamp) into a DEPTH-entry FIFO.
//  A debug consumer drains the FIFO over a valid/ready port. Sits beside the writeback stage.
//  Fed by the same retire signals that drive the register file.
// PARAMETERS
//  XLEN          32  data/PC width
//  ADDR_W        5   register index width (2**ADDR_W architectural regs, x0 hardwired zero)
//  DEPTH         16  FIFO entries; power of two, >=2
//  TS_W          16  timestamp counter width
//  STALL_ON_FULL 0   0: drop new records when full; 1: assert ret_stall when full
// PORTS
//  clk        in   1            clock, rising edge
//  reset      in   1            asynchronous, active-low reset
//  en         in   1            trace enable
//  clear      in   1            synchronous flush of FIFO, counters, flags
//  ret_valid  in   1            instruction retires this cycle
//  ret_pc     in   XLEN         PC of retiring instruction
//  ret_rd     in   ADDR_W       destination register index
//  ret_we     in   1            register write performed
//  ret_wdata  in   XLEN         value written
//  ret_stall  out  1            stall request to pipeline (STALL_ON_FULL=1 only, else 0)
//  out_valid  out  1            head record available
//  out_ready  in   1            consumer accepts head record
//  out_pc     out  XLEN         head record fields (show-ahead)
//  out_rd     out  ADDR_W
//  out_we     out  1
//  out_wdata  out  XLEN
//  out_ts     out  TS_W
//  count      out  $clog2(DEPTH)+1  entries held
//  drop_cnt   out  16           records lost, saturates at 16'hFFFF
//  overflow   out  1            sticky, set on first drop
// BEHAVIOUR
//  - Reset (reset==0, async): FIFO empty, all outputs and ts counter 0.
//  - ts: free-running and wraps at 2**TS_W. Increments each cycle en==1 and holds when en==0.
//    Each record stores the ts value of its capture cycle.
//  - push = ret_valid & en & (!full | pop).
//    Full FIFO with a simultaneous pop still accepts the push.
//  - pop = out_valid & out_ready. out_valid = !empty.
//    out_* reflect the head entry and are stable while out_valid & !out_ready.
//  - Latency: a record pushed at edge N is visible on out_* after edge N.
//    No combinational bypass: an empty FIFO with push shows out_valid=0 that cycle.
//  - x0 rule: ret_rd==0 stores we=0 and wdata=0 regardless of inputs.
//  - Drop: ret_valid & en & full & !pop discards the record.
//    drop_cnt increments (saturating) and overflow sets. This applies in both modes.
//  - ret_stall = STALL_ON_FULL & full & !pop. It is combinational from out_ready.
//  - en==0: no pushes and no drops; draining continues.
//  - clear==1: FIFO empty, ts/drop_cnt/overflow zeroed next cycle.
//    clear wins over a same-cycle push/pop.
//  - Pointers: ADDR=$clog2(DEPTH) bits, wrap modulo DEPTH.
//    count is maintained with +1/-1/0 per cycle and never exceeds DEPTH.
// STRUCTURE
//  - Shared header src/trace_defs.v: record field offsets/width (REC_W = TS_W+XLEN+ADDR_W+1+XLEN),
//    mode constants TRACE_DROP=0 and TRACE_STALL=1.
//  - One sub-module, sync_fifo #(WIDTH,DEPTH): storage, pointers, count, full/empty, show-ahead head.
//    Top level holds the ts counter, x0 masking, drop/overflow logic and the stall output.
// TESTING
//  1. Hold reset low mid-run with 5 entries queued.
//     -> out_valid=0, count=0, drop_cnt=0, ts=0 immediately (async).
//  2. Retire pc=0x0,0x4,0x8 with rd=1,2,3, wdata=5,-3,7, out_ready=0.
//     -> count=3. Then out_ready=1 -> pc 0x0,0x4,0x8 in order, ts 0,1,2.
//  3. DEPTH=16, drop mode: 20 back-to-back retires, out_ready=0.
//     -> count=16, drop_cnt=4, overflow=1; head pc is that of the first record.
//  4. Full FIFO, ret_valid=1 and out_ready=1 same cycle.
//     -> count stays 16, drop_cnt unchanged, ret_stall=0.
//  5. STALL_ON_FULL=1, full, out_ready=0 -> ret_stall=1. out_ready=1 -> ret_stall=0 same cycle.
//  6. Retire rd=0, we=1, wdata=0x1234 -> record out_we=0, out_wdata=0.
//     Then clear with ret_valid=1 -> count=0, drop_cnt=0.

Source files
------------

// File: rtl/retire_trace_buffer_pkg.sv
// Shared definitions for the retire trace buffer: record layout width and
// the two full-FIFO handling modes.
package retire_trace_buffer_pkg;

    // Full-FIFO handling modes selected by STALL_ON_FULL.
    localparam int TRACE_DROP  = 0;
    localparam int TRACE_STALL = 1;

    // Packed record layout, MSB to LSB: {ts, pc, rd, we, wdata}.
    function automatic int rec_w(input int xlen, input int addr_w, input int ts_w);
        return ts_w + xlen + addr_w + 1 + xlen;
    endfunction

endpackage

// File: rtl/retire_trace_buffer_sync_fifo.sv
// Synchronous show-ahead FIFO: storage, wrapping pointers, occupancy count.
// The head word reads as zero while empty so stale storage never leaks out.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int ADDR = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR-1:0]  r_wr_ptr;
    logic [ADDR-1:0]  r_rd_ptr;
    logic [ADDR:0]    r_count;
    logic             w_pop;
    logic             w_push;

    // Pop only a real entry; a push into a full FIFO needs a same-cycle pop.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    // Pointer and occupancy bookkeeping; clear overrides any push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; data words carry no reset.
    always_ff @(posedge clk) begin
        if (w_push && !clear) r_mem[r_wr_ptr] <= wdata;
    end

    assign count = r_count;
    assign full  = (r_count == (ADDR+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign rdata = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace capture: stamps each retired instruction with a timestamp,
// masks writes to x0, queues records for a debug consumer, and accounts for
// records lost when the queue is full (optionally requesting a stall).
module retire_trace_buffer
    import retire_trace_buffer_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int ADDR_W        = 5,
    parameter int DEPTH         = 16,
    parameter int TS_W          = 16,
    parameter int STALL_ON_FULL = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     clear,
    input  logic                     ret_valid,
    input  logic [XLEN-1:0]          ret_pc,
    input  logic [ADDR_W-1:0]        ret_rd,
    input  logic                     ret_we,
    input  logic [XLEN-1:0]          ret_wdata,
    output logic                     ret_stall,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [ADDR_W-1:0]        out_rd,
    output logic                     out_we,
    output logic [XLEN-1:0]          out_wdata,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              drop_cnt,
    output logic                     overflow
);

    localparam int   REC_W      = rec_w(XLEN, ADDR_W, TS_W);
    localparam logic STALL_MODE = (STALL_ON_FULL == TRACE_STALL);

    logic [TS_W-1:0]  r_ts;
    logic [15:0]      r_drop_cnt;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_room;
    logic             w_push;
    logic             w_drop;
    logic             w_is_x0;
    logic             w_we;
    logic [XLEN-1:0]  w_wdata;
    logic [REC_W-1:0] w_rec;
    logic [REC_W-1:0] w_head;

    // A full queue still has room for the incoming record if the head leaves this cycle.
    assign w_pop   = ~w_empty & out_ready;
    assign w_room  = ~w_full | w_pop;
    assign w_push  = ret_valid & en & w_room;
    assign w_drop  = ret_valid & en & ~w_room;

    // x0 is hardwired zero, so a retire to it never records a write.
    assign w_is_x0 = (ret_rd == '0);
    assign w_we    = ret_we & ~w_is_x0;
    assign w_wdata = w_is_x0 ? '0 : ret_wdata;
    assign w_rec   = {r_ts, ret_pc, ret_rd, w_we, w_wdata};

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_rec),
        .rdata (w_head),
        .count (count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign {out_ts, out_pc, out_rd, out_we, out_wdata} = w_head;
    assign out_valid = ~w_empty;
    assign ret_stall = STALL_MODE & w_full & ~w_pop;
    assign drop_cnt  = r_drop_cnt;
    assign overflow  = r_overflow;

    // Timestamp advances only while tracing is enabled and wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     r_ts <= '0;
        else if (clear) r_ts <= '0;
        else if (en)    r_ts <= r_ts + 1'b1;
    end

    // Lost-record accounting: saturating counter plus sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
            r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: drop-mode and stall-mode instances share one
// stimulus stream; a queue-based reference model feeds a scoreboard that a
// negedge monitor drains whenever the consumer takes the head record.
module tb_retire_trace_buffer;

    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wdata;
        logic [15:0] ts;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset, en, clear, ret_valid, ret_we, out_ready;
    logic [31:0] ret_pc, ret_wdata;
    logic [4:0]  ret_rd;

    logic        d_stall, d_valid, d_we, d_ovf;
    logic [31:0] d_pc, d_wdata;
    logic [4:0]  d_rd, d_count;
    logic [15:0] d_ts, d_drop;
    logic        s_stall, s_valid, s_we, s_ovf;
    logic [31:0] s_pc, s_wdata;
    logic [4:0]  s_rd, s_count;
    logic [15:0] s_ts, s_drop;

    rec_t exp_q[$];
    int   m_ts = 0, m_drops = 0;
    bit   m_ovf = 0, mon_on = 0;
    int   n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    retire_trace_buffer #(.STALL_ON_FULL(0)) u_dut_drop (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .ret_valid(ret_valid),
        .ret_pc(ret_pc), .ret_rd(ret_rd), .ret_we(ret_we), .ret_wdata(ret_wdata),
        .ret_stall(d_stall), .out_valid(d_valid), .out_ready(out_ready),
        .out_pc(d_pc), .out_rd(d_rd), .out_we(d_we), .out_wdata(d_wdata), .out_ts(d_ts),
        .count(d_count), .drop_cnt(d_drop), .overflow(d_ovf));

    retire_trace_buffer #(.STALL_ON_FULL(1)) u_dut_stall (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .ret_valid(ret_valid),
        .ret_pc(ret_pc), .ret_rd(ret_rd), .ret_we(ret_we), .ret_wdata(ret_wdata),
        .ret_stall(s_stall), .out_valid(s_valid), .out_ready(out_ready),
        .out_pc(s_pc), .out_rd(s_rd), .out_we(s_we), .out_wdata(s_wdata), .out_ts(s_ts),
        .count(s_count), .drop_cnt(s_drop), .overflow(s_ovf));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT state against the model and retire accepted heads.
    always @(negedge clk) begin
        if (mon_on && reset) begin
            int   sz;
            rec_t h;
            sz = exp_q.size();
            chk("d_valid", d_valid, sz != 0);
            chk("s_valid", s_valid, sz != 0);
            chk("d_count", d_count, sz);
            chk("s_count", s_count, sz);
            chk("d_drop", d_drop, m_drops);
            chk("s_drop", s_drop, m_drops);
            chk("d_ovf", d_ovf, m_ovf);
            chk("s_ovf", s_ovf, m_ovf);
            chk("d_stall", d_stall, 1'b0);
            chk("s_stall", s_stall, (sz == DEPTH) && !out_ready);
            if (sz != 0) begin
                h = exp_q[0];
                chk("d_pc", d_pc, h.pc);       chk("s_pc", s_pc, h.pc);
                chk("d_rd", d_rd, h.rd);       chk("s_rd", s_rd, h.rd);
                chk("d_we", d_we, h.we);       chk("s_we", s_we, h.we);
                chk("d_wdata", d_wdata, h.wdata); chk("s_wdata", s_wdata, h.wdata);
                chk("d_ts", d_ts, h.ts);       chk("s_ts", s_ts, h.ts);
                if (out_ready && !clear) void'(exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus: apply the model's view of the edge just taken.
    task automatic step();
        rec_t r;
        @(posedge clk);
        #1;
        if (reset) begin
            if (clear) begin
                exp_q.delete();
                m_ts = 0; m_drops = 0; m_ovf = 0;
            end else begin
                if (ret_valid && en) begin
                    if (exp_q.size() < DEPTH) begin
                        r.pc    = ret_pc;
                        r.rd    = ret_rd;
                        r.we    = (ret_rd != 0) && ret_we;
                        r.wdata = (ret_rd != 0) ? ret_wdata : 32'h0;
                        r.ts    = m_ts[15:0];
                        exp_q.push_back(r);
                    end else begin
                        if (m_drops < 65535) m_drops++;
                        m_ovf = 1;
                    end
                end
                if (en) m_ts = (m_ts + 1) % 65536;
            end
        end
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [4:0] rd,
                          input logic we, input logic [31:0] wd);
        ret_valid = 1; ret_pc = pc; ret_rd = rd; ret_we = we; ret_wdata = wd;
        step();
        ret_valid = 0;
    endtask

    task automatic do_clear();
        clear = 1; step(); clear = 0;
    endtask

    initial begin
        reset = 0; en = 1; clear = 0; ret_valid = 0; ret_we = 0; out_ready = 0;
        ret_pc = 0; ret_rd = 0; ret_wdata = 0;
        repeat (3) @(posedge clk);
        #2 reset = 1; mon_on = 1;

        // In-order capture with timestamps 0,1,2
        do_clear();
        retire(32'h0, 5'd1, 1, 32'd5);
        retire(32'h4, 5'd2, 1, 32'hFFFF_FFFD);
        retire(32'h8, 5'd3, 1, 32'd7);
        chk("t2_count", d_count, 3);
        chk("t2_head_pc", d_pc, 32'h0);
        chk("t2_head_ts", d_ts, 16'd0);
        out_ready = 1;
        repeat (3) step();
        chk("t2_drained", d_valid, 1'b0);
        out_ready = 0;

        // x0 retire masks write flag and data
        retire(32'h100, 5'd0, 1, 32'h1234);
        chk("x0_we", d_we, 1'b0);
        chk("x0_wdata", d_wdata, 32'h0);
        out_ready = 1; step(); out_ready = 0;

        // Overfill in drop mode
        do_clear();
        for (int i = 0; i < 20; i++) retire(32'h1000 + 4*i, 5'(i + 1), 1, $urandom);
        chk("t3_count", d_count, 16);
        chk("t3_drop", d_drop, 4);
        chk("t3_ovf", d_ovf, 1'b1);
        chk("t3_head_pc", d_pc, 32'h1000);
        chk("t5_stall_full", s_stall, 1'b1);

        // Full with simultaneous pop and push: no drop, stall released combinationally
        out_ready = 1; ret_valid = 1; ret_pc = 32'h2000; ret_rd = 5'd9; ret_we = 1; ret_wdata = 32'hABCD;
        #1;
        chk("t5_stall_release", s_stall, 1'b0);
        chk("t4_d_stall", d_stall, 1'b0);
        #0 step();
        ret_valid = 0;
        chk("t4_count", d_count, 16);
        chk("t4_drop", d_drop, 4);

        // Drain to five entries, then asynchronous reset mid-cycle
        repeat (11) step();
        out_ready = 0;
        chk("t1_pre_count", d_count, 5);
        #1 reset = 0;
        #1;
        chk("t1_valid", d_valid, 1'b0);
        chk("t1_count", d_count, 0);
        chk("t1_drop", d_drop, 0);
        chk("t1_ovf", d_ovf, 1'b0);
        chk("t1_ts", d_ts, 16'd0);
        exp_q.delete(); m_ts = 0; m_drops = 0; m_ovf = 0;
        step();
        reset = 1;

        // Clear beats a same-cycle retire
        retire(32'h40, 5'd4, 1, 32'h1);
        ret_valid = 1; ret_pc = 32'h44; ret_rd = 5'd5; ret_we = 1; ret_wdata = 32'h2;
        do_clear();
        ret_valid = 0;
        chk("t6_count", d_count, 0);
        chk("t6_drop", d_drop, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            en        = ($urandom_range(0, 7) != 0);
            ret_valid = ($urandom_range(0, 3) != 0);
            out_ready = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 99) == 0);
            ret_pc    = $urandom;
            ret_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            ret_we    = $urandom_range(0, 1);
            ret_wdata = $urandom;
            step();
        end
        ret_valid = 0; clear = 0; en = 1; out_ready = 1;
        repeat (20) step();
        chk("final_empty", d_valid, 1'b0);

        mon_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
